// File: rtl/ppu_vout_align_if.sv
// ppu_vout_align_if
// Bundles the video data, sync, delay/filter control and pin outputs of the
// PPU video output aligner so they travel as one port.
//   master : the side that supplies video/control and observes the outputs
//   slave  : the aligner itself
// Signals:
//   vdata_i      colour data in, channel 0 in the LSBs
//   sync_i       {nVSYNC, nBLANK, nHSYNC, nCSYNC}, active-low
//   dly_sel      requested extra colour delay in cycles
//   apply_now    adopt dly_sel / filter code immediately
//   filter_set   00 auto, 01 9.5MHz, 10 18MHz, 11 bypass
//   linedbl_en   line doubler active (feeds auto filter mode)
//   en_rgsb      sync-on-green enable
//   en_ypbpr     YPbPr enable
//   use_vga      route H/V sync to the filter pins instead of F1/F2
//   VD_o         aligned colour out
//   Sync_o       registered sync
//   nCSYNC       {csync, csync-for-DAC}
//   nVSYNC_or_F2 vsync or F2 filter select
//   nHSYNC_or_F1 hsync or F1 filter select
//   dly_cur      currently applied delay
//   upd_pending  a delay/filter change waits for the next frame boundary
interface ppu_vout_align_if #(
  parameter int COLOR_W = 8,
  parameter int CH      = 3,
  parameter int MAX_DLY = 4
);
  localparam int W  = CH * COLOR_W;
  localparam int DW = $clog2(MAX_DLY);

  logic [W-1:0]  vdata_i;
  logic [3:0]    sync_i;
  logic [DW-1:0] dly_sel;
  logic          apply_now;
  logic [1:0]    filter_set;
  logic          linedbl_en;
  logic          en_rgsb;
  logic          en_ypbpr;
  logic          use_vga;
  logic [W-1:0]  VD_o;
  logic [3:0]    Sync_o;
  logic [1:0]    nCSYNC;
  logic          nVSYNC_or_F2;
  logic          nHSYNC_or_F1;
  logic [DW-1:0] dly_cur;
  logic          upd_pending;

  modport master (
    output vdata_i, sync_i, dly_sel, apply_now, filter_set, linedbl_en,
           en_rgsb, en_ypbpr, use_vga,
    input  VD_o, Sync_o, nCSYNC, nVSYNC_or_F2, nHSYNC_or_F1, dly_cur,
           upd_pending
  );

  modport slave (
    input  vdata_i, sync_i, dly_sel, apply_now, filter_set, linedbl_en,
           en_rgsb, en_ypbpr, use_vga,
    output VD_o, Sync_o, nCSYNC, nVSYNC_or_F2, nHSYNC_or_F1, dly_cur,
           upd_pending
  );
endinterface

// File: rtl/ppu_vout_align.sv
// ppu_vout_align
// Aligns PPU colour data against the sync stream by a selectable number of
// extra cycles and drives the sync / video-filter select pins. Changes to the
// colour delay and filter code are held back until the next nVSYNC falling
// edge so a frame is never split between two settings, unless apply_now
// forces immediate adoption.
// Ports:
//   VCLK   video clock (sole clock)
//   nVRST  asynchronous active-low reset
//   bus    ppu_vout_align_if.slave (video in/out, sync, control, pins)
// Optional feature:
//   PPU_VOUT_BLANK_EN  when defined, VD_o is zeroed in cycles whose
//                      registered nBLANK (Sync_o[2]) is low.
module ppu_vout_align #(
  parameter int COLOR_W = 8,
  parameter int CH      = 3,
  parameter int MAX_DLY = 4
) (
  input logic VCLK,
  input logic nVRST,
  ppu_vout_align_if.slave bus
);
  localparam int W  = CH * COLOR_W;
  localparam int DW = $clog2(MAX_DLY);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  stage [MAX_DLY-1];
  logic [W-1:0]  tap;
  logic [W-1:0]  vd_q;
  logic [3:0]    sync_q;
  logic [DW-1:0] dly_q, dly_req;
  logic [1:0]    filt_q, filt_req;
  logic          boundary, differs, load, pending;

  // Requested delay, clamped for non-power-of-2 MAX_DLY. The operand is
  // widened by one bit so the compare is meaningful for every MAX_DLY.
  always_comb begin
    dly_req = bus.dly_sel;
    if ({1'b0, bus.dly_sel} >= (DW+1)'(MAX_DLY))
      dly_req = DW'(MAX_DLY - 1);
  end

  // Filter code {F1,F2} that the current filter_set / line doubler asks for.
  always_comb begin
    case (bus.filter_set)
      2'b11:   filt_req = 2'b11;
      2'b10:   filt_req = 2'b01;
      2'b01:   filt_req = 2'b00;
      default: filt_req = bus.linedbl_en ? 2'b01 : 2'b00;
    endcase
  end

  assign boundary = sync_q[3] & ~bus.sync_i[3];
  assign differs  = {dly_req, filt_req} != {dly_q, filt_q};

  // Colour history. stage[j] holds the input from j+1 cycles ago; the
  // shortest path (dly 0) taps vdata_i directly so the output register
  // alone provides the single mandatory cycle. History survives delay
  // changes on purpose.
  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      for (int j = 0; j < MAX_DLY-1; j++) stage[j] <= '0;
    end else begin
      stage[0] <= bus.vdata_i;
      for (int j = 1; j < MAX_DLY-1; j++) stage[j] <= stage[j-1];
    end
  end

  // Delay tap selection feeding the output register.
  always_comb begin
    tap = bus.vdata_i;
    for (int k = 1; k < MAX_DLY; k++)
      if (dly_q == DW'(k)) tap = stage[k-1];
  end

  // Output video and sync registers; blank gating uses the same sync_i
  // sample that becomes Sync_o in the cycle the colour appears.
  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      vd_q   <= '0;
      sync_q <= '0;
    end else begin
`ifdef PPU_VOUT_BLANK_EN
      vd_q   <= bus.sync_i[2] ? tap : '0;
`else
      vd_q   <= tap;
`endif
      sync_q <= bus.sync_i;
    end
  end

  // Applied delay and filter code, loaded from the live inputs on the
  // adopting edge so the latest request wins.
  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      dly_q  <= '0;
      filt_q <= '0;
    end else if (load) begin
      dly_q  <= dly_req;
      filt_q <= filt_req;
    end
  end

  // Update FSM state register.
  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Update FSM next state: apply_now always lands in IDLE; a pending update
  // is dropped if the request reverts to what is already applied.
  always_comb begin
    state_d = state_q;
    if (bus.apply_now) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (differs) state_d = PENDING;
        PENDING: if (boundary || !differs) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Update FSM outputs.
  always_comb begin
    pending = (state_q == PENDING);
    load    = bus.apply_now | (pending & boundary);
  end

  assign bus.VD_o         = vd_q;
  assign bus.Sync_o       = sync_q;
  assign bus.dly_cur      = dly_q;
  assign bus.upd_pending  = pending;
  assign bus.nCSYNC       = {sync_q[0], (bus.en_rgsb | bus.en_ypbpr) ? sync_q[0] : 1'b0};
  assign bus.nHSYNC_or_F1 = bus.use_vga ? sync_q[1] : filt_q[1];
  assign bus.nVSYNC_or_F2 = bus.use_vga ? sync_q[3] : filt_q[0];
endmodule
